// File: rtl/spi_master_fifo.sv
// SPI master with byte-lane CTRL/STATUS registers and TX/RX FIFOs for the sysio bus.
// Define SPI_MASTER_IRQ_EN to add irq_o and the CTRL[31:29] interrupt enables.
module spi_master_fifo #(
  parameter int DATA_W     = 32,
  parameter int CS_NUM     = 4,
  parameter int FIFO_DEPTH = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [7:0]        waddr_i,
  input  logic [31:0]       data_i,
  input  logic [3:0]        sel_i,
  input  logic              we_i,
  input  logic [7:0]        raddr_i,
  input  logic              rd_i,
  output logic [31:0]       data_o,
  output logic              spi_clk,
  output logic              spi_mosi,
  input  logic              spi_miso,
  output logic [CS_NUM-1:0] spi_cs_n
`ifdef SPI_MASTER_IRQ_EN
  ,
  output logic              irq_o
`endif
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam logic [AW:0] DEPTH_C = FIFO_DEPTH[AW:0];
  localparam logic [5:0]  DW6     = DATA_W[5:0];
  localparam logic [3:0]  A_CTRL  = 4'h0;
  localparam logic [3:0]  A_TX    = 4'h4;
  localparam logic [3:0]  A_RX    = 4'h8;
  localparam logic [3:0]  A_STAT  = 4'hC;
`ifdef SPI_MASTER_IRQ_EN
  localparam logic [31:0] CTRL_MASK = 32'hFFFF_0F3F;
`else
  localparam logic [31:0] CTRL_MASK = 32'h1FFF_0F3F;
`endif

  typedef enum logic [1:0] {IDLE, SETUP, SHIFT, HOLD} state_t;

  function automatic logic [CS_NUM-1:0] cs_decode(input logic [3:0] idx);
    logic [CS_NUM-1:0] m;
    m = '0;
    for (int i = 0; i < CS_NUM; i++) m[i] = (idx == 4'(i));
    return m;
  endfunction

  function automatic logic sh_head(input logic [DATA_W-1:0] sh, input logic lsbf);
    return lsbf ? sh[0] : sh[DATA_W-1];
  endfunction

  function automatic logic [DATA_W-1:0] sh_next(input logic [DATA_W-1:0] sh, input logic lsbf);
    return lsbf ? (sh >> 1) : (sh << 1);
  endfunction

  function automatic logic [DATA_W-1:0] sh_in(input logic [DATA_W-1:0] sh, input logic b,
                                              input logic lsbf);
    return lsbf ? {b, sh[DATA_W-1:1]} : {sh[DATA_W-2:0], b};
  endfunction

  logic [31:0]        ctrl_q;
  logic               rx_ovf_q;
  logic [31:0]        data_q;
  logic [AW:0]        tx_wptr_q, tx_rptr_q, rx_wptr_q, rx_rptr_q;
  logic [DATA_W-1:0]  tx_mem [FIFO_DEPTH];
  logic [DATA_W-1:0]  rx_mem [FIFO_DEPTH];

  state_t             state_q;
  logic [7:0]         div_cnt_q;
  logic [6:0]         edge_cnt_q;
  logic               sclk_q, mosi_q;
  logic [DATA_W-1:0]  tx_sh_q, rx_sh_q;
  logic               cpha_f_q, lsbf_f_q;
  logic [5:0]         len_f_q;
  logic [CS_NUM-1:0]  frame_cs_q, man_cs_q;

  logic               ctrl_en, ctrl_cpol, ctrl_cpha, ctrl_lsbf, ctrl_cs_auto, ctrl_cs_man;
  logic [3:0]         ctrl_cs_idx;
  logic [7:0]         ctrl_div;
  logic [5:0]         ctrl_bits;
  logic [AW:0]        tx_count, rx_count;
  logic               tx_full, tx_empty, rx_full, rx_empty, busy;
  logic               tx_push, rx_pop, rx_push, rx_ovf_set;
  logic               tick, frame_start, edge_odd, do_sample, do_shift, last_edge;
  logic [DATA_W-1:0]  tx_head, ld_sh, rx_sh_nx, rx_word;
  logic [31:0]        rd_mux, status;
  logic               unused_addr_hi;

  assign unused_addr_hi = ^{waddr_i[7:4], raddr_i[7:4], data_i};

  assign ctrl_en      = ctrl_q[0];
  assign ctrl_cpol    = ctrl_q[1];
  assign ctrl_cpha    = ctrl_q[2];
  assign ctrl_lsbf    = ctrl_q[3];
  assign ctrl_cs_auto = ctrl_q[4];
  assign ctrl_cs_man  = ctrl_q[5];
  assign ctrl_cs_idx  = ctrl_q[11:8];
  assign ctrl_div     = ctrl_q[23:16];

  always_comb begin
    ctrl_bits = {1'b0, ctrl_q[28:24]} + 6'd1;
    if (ctrl_bits > DW6) ctrl_bits = DW6;
  end

  assign tx_count = tx_wptr_q - tx_rptr_q;
  assign rx_count = rx_wptr_q - rx_rptr_q;
  assign tx_full  = (tx_count == DEPTH_C);
  assign tx_empty = (tx_count == '0);
  assign rx_full  = (rx_count == DEPTH_C);
  assign rx_empty = (rx_count == '0);
  assign busy     = (state_q != IDLE) || (ctrl_en && !tx_empty);

  assign tx_push = we_i && (waddr_i[3:0] == A_TX) && (|sel_i) && !tx_full;
  assign rx_pop  = rd_i && (raddr_i[3:0] == A_RX) && !rx_empty;

  // Half-period pacing uses the live DIV; >= keeps a shrinking DIV from wrapping the counter.
  assign tick        = (div_cnt_q >= ctrl_div);
  assign frame_start = ctrl_en && !tx_empty &&
                       ((state_q == IDLE) || (state_q == HOLD && tick && !ctrl_cs_auto));
  assign edge_odd    = ~edge_cnt_q[0];
  assign do_sample   = (state_q == SHIFT) && tick && (edge_odd != cpha_f_q);
  assign do_shift    = (state_q == SHIFT) && tick && (edge_odd == cpha_f_q);
  assign last_edge   = (state_q == SHIFT) && tick && ((edge_cnt_q + 7'd1) == {len_f_q, 1'b0});
  assign rx_push     = last_edge && !rx_full;
  assign rx_ovf_set  = last_edge && rx_full;

  // Frame word is masked to its length and MSB-first frames are left-aligned so the head is the top bit.
  assign tx_head  = tx_mem[tx_rptr_q[AW-1:0]] & ({DATA_W{1'b1}} >> (DW6 - ctrl_bits));
  assign ld_sh    = ctrl_lsbf ? tx_head : (tx_head << (DW6 - ctrl_bits));
  assign rx_sh_nx = do_sample ? sh_in(rx_sh_q, spi_miso, lsbf_f_q) : rx_sh_q;
  assign rx_word  = lsbf_f_q ? (rx_sh_nx >> (DW6 - len_f_q)) : rx_sh_nx;

  assign status = {8'd0, 8'(rx_count), 8'(tx_count), 2'd0,
                   rx_ovf_q, rx_empty, rx_full, tx_empty, tx_full, busy};

  always_comb begin
    rd_mux = '0;
    case (raddr_i[3:0])
      A_CTRL: rd_mux = ctrl_q;
      A_RX:   rd_mux = rx_empty ? 32'd0 : 32'(rx_mem[rx_rptr_q[AW-1:0]]);
      A_STAT: rd_mux = status;
      default: rd_mux = '0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (tx_push) tx_mem[tx_wptr_q[AW-1:0]] <= data_i[DATA_W-1:0];
    if (rx_push) rx_mem[rx_wptr_q[AW-1:0]] <= rx_word;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ctrl_q    <= '0;
      rx_ovf_q  <= 1'b0;
      data_q    <= '0;
      tx_wptr_q <= '0;
      tx_rptr_q <= '0;
      rx_wptr_q <= '0;
      rx_rptr_q <= '0;
    end else begin
      if (we_i && waddr_i[3:0] == A_CTRL) begin
        for (int b = 0; b < 4; b++)
          if (sel_i[b]) ctrl_q[8*b +: 8] <= data_i[8*b +: 8] & CTRL_MASK[8*b +: 8];
      end
      if (rx_ovf_set)
        rx_ovf_q <= 1'b1;
      else if (we_i && waddr_i[3:0] == A_STAT && sel_i[0] && data_i[5])
        rx_ovf_q <= 1'b0;
      if (rd_i) data_q <= rd_mux;
      if (tx_push)     tx_wptr_q <= tx_wptr_q + 1'b1;
      if (frame_start) tx_rptr_q <= tx_rptr_q + 1'b1;
      if (rx_push)     rx_wptr_q <= rx_wptr_q + 1'b1;
      if (rx_pop)      rx_rptr_q <= rx_rptr_q + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      div_cnt_q  <= '0;
      edge_cnt_q <= '0;
      sclk_q     <= 1'b0;
      mosi_q     <= 1'b0;
      tx_sh_q    <= '0;
      rx_sh_q    <= '0;
      cpha_f_q   <= 1'b0;
      lsbf_f_q   <= 1'b0;
      len_f_q    <= '0;
      frame_cs_q <= '0;
      man_cs_q   <= '0;
    end else begin
      man_cs_q  <= ctrl_cs_man ? cs_decode(ctrl_cs_idx) : '0;
      div_cnt_q <= (state_q == IDLE || tick) ? 8'd0 : div_cnt_q + 8'd1;
      if (frame_start) begin
        state_q    <= SETUP;
        sclk_q     <= ctrl_cpol;
        cpha_f_q   <= ctrl_cpha;
        lsbf_f_q   <= ctrl_lsbf;
        len_f_q    <= ctrl_bits;
        frame_cs_q <= cs_decode(ctrl_cs_idx);
        edge_cnt_q <= '0;
        rx_sh_q    <= '0;
        if (!ctrl_cpha) begin
          mosi_q  <= sh_head(ld_sh, ctrl_lsbf);
          tx_sh_q <= sh_next(ld_sh, ctrl_lsbf);
        end else begin
          tx_sh_q <= ld_sh;
        end
      end else begin
        case (state_q)
          IDLE:  sclk_q <= ctrl_cpol;
          SETUP: if (tick) state_q <= SHIFT;
          SHIFT: if (tick) begin
            sclk_q     <= ~sclk_q;
            edge_cnt_q <= edge_cnt_q + 7'd1;
            rx_sh_q    <= rx_sh_nx;
            if (do_shift) begin
              mosi_q  <= sh_head(tx_sh_q, lsbf_f_q);
              tx_sh_q <= sh_next(tx_sh_q, lsbf_f_q);
            end
            if (last_edge) state_q <= HOLD;
          end
          HOLD: if (tick) begin
            state_q    <= IDLE;
            frame_cs_q <= '0;
          end
          default: state_q <= IDLE;
        endcase
      end
    end
  end

`ifdef SPI_MASTER_IRQ_EN
  logic irq_q;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) irq_q <= 1'b0;
    else        irq_q <= |(ctrl_q[31:29] & {rx_ovf_q, tx_empty, ~rx_empty});
  end
  assign irq_o = irq_q;
`endif

  assign data_o   = data_q;
  assign spi_clk  = sclk_q;
  assign spi_mosi = mosi_q;
  assign spi_cs_n = ~(frame_cs_q | man_cs_q);

endmodule

// File: tb/tb_spi_master_fifo.sv
// Directed self-checking bench for spi_master_fifo: registers, SPI modes, FIFOs, reset.
module tb_spi_master_fifo;
  localparam int CS_NUM     = 4;
  localparam int FIFO_DEPTH = 8;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [7:0]  waddr_i, raddr_i;
  logic [31:0] data_i, data_o;
  logic [3:0]  sel_i;
  logic        we_i, rd_i;
  logic        spi_clk, spi_mosi, spi_miso;
  logic [CS_NUM-1:0] spi_cs_n;
  logic        loop_en, miso_val;
`ifdef SPI_MASTER_IRQ_EN
  logic        irq;
`endif

  int total = 0;
  int bad   = 0;

  assign spi_miso = loop_en ? spi_mosi : miso_val;

  always #5 clk = ~clk;

  spi_master_fifo #(.DATA_W(32), .CS_NUM(CS_NUM), .FIFO_DEPTH(FIFO_DEPTH)) dut (
    .clk(clk), .rst_n(rst_n), .waddr_i(waddr_i), .data_i(data_i), .sel_i(sel_i),
    .we_i(we_i), .raddr_i(raddr_i), .rd_i(rd_i), .data_o(data_o), .spi_clk(spi_clk),
    .spi_mosi(spi_mosi), .spi_miso(spi_miso), .spi_cs_n(spi_cs_n)
`ifdef SPI_MASTER_IRQ_EN
    , .irq_o(irq)
`endif
  );

  task automatic bus_write(input logic [7:0] a, input logic [31:0] d, input logic [3:0] s);
    @(negedge clk);
    waddr_i = a; data_i = d; sel_i = s; we_i = 1'b1;
    @(negedge clk);
    we_i = 1'b0; sel_i = 4'h0;
  endtask

  task automatic bus_read(input logic [7:0] a, output logic [31:0] d);
    @(negedge clk);
    raddr_i = a; rd_i = 1'b1;
    @(negedge clk);
    rd_i = 1'b0;
    d = data_o;
  endtask

  // Watches one CS-low window (possibly several back-to-back frames) until CS returns high.
  task automatic monitor_frames(input int max_cyc, input logic [3:0] cs_exp, output int rises,
                                output int cs_low, output logic [31:0] bits, output int cs_err,
                                output logic timed_out);
    logic prev, seen_low;
    rises = 0; cs_low = 0; bits = '0; cs_err = 0; timed_out = 1'b1;
    prev = spi_clk; seen_low = 1'b0;
    for (int i = 0; i < max_cyc; i++) begin
      @(negedge clk);
      if (spi_cs_n != 4'hF) begin
        seen_low = 1'b1;
        cs_low++;
        if (spi_cs_n !== cs_exp) cs_err++;
      end else if (seen_low) begin
        timed_out = 1'b0;
        break;
      end
      if (spi_clk && !prev) begin
        rises++;
        bits = {bits[30:0], spi_mosi};
      end
      prev = spi_clk;
    end
  endtask

  task automatic test_reset();
    logic [31:0] d;
    rst_n = 1'b0; waddr_i = '0; raddr_i = '0; data_i = '0; sel_i = '0; we_i = 0; rd_i = 0;
    loop_en = 1'b1; miso_val = 1'b0;
    repeat (3) @(negedge clk);
    total++; if ({spi_cs_n, spi_clk, spi_mosi} !== 6'b111100) begin
      bad++; $display("FAIL reset_pins got cs=%b clk=%b mosi=%b exp cs=1111 clk=0 mosi=0",
                      spi_cs_n, spi_clk, spi_mosi); end
    total++; if (data_o !== 32'h0) begin bad++; $display("FAIL reset_data_o got %h exp 0", data_o); end
    rst_n = 1'b1;
    bus_read(8'h0C, d);
    total++; if (d !== 32'h14) begin bad++; $display("FAIL reset_status got %h exp 00000014", d); end
    bus_read(8'h00, d);
    total++; if (d !== 32'h0) begin bad++; $display("FAIL reset_ctrl got %h exp 0", d); end
  endtask

  task automatic test_ctrl_regs();
    logic [31:0] d, exp_all;
`ifdef SPI_MASTER_IRQ_EN
    exp_all = 32'hFFFF_0F3E;
`else
    exp_all = 32'h1FFF_0F3E;
`endif
    bus_write(8'h00, 32'hFFFF_FFFE, 4'hF);
    bus_read(8'h00, d);
    total++; if (d !== exp_all) begin bad++; $display("FAIL ctrl_mask got %h exp %h", d, exp_all); end
    total++; if (spi_cs_n !== 4'hF) begin bad++; $display("FAIL cs_idx_out_of_range got %b exp 1111", spi_cs_n); end
    total++; if (spi_clk !== 1'b1) begin bad++; $display("FAIL idle_cpol1 got %b exp 1", spi_clk); end
    bus_write(8'h00, 32'h0000_0320, 4'hF);
    repeat (2) @(negedge clk);
    total++; if (spi_cs_n !== 4'b0111) begin bad++; $display("FAIL cs_manual got %b exp 0111", spi_cs_n); end
    bus_write(8'h00, 32'h0, 4'hF);
    bus_write(8'h00, 32'hFFFF_FFFF, 4'b0010);
    bus_read(8'h00, d);
    total++; if (d !== 32'h0000_0F00) begin bad++; $display("FAIL ctrl_byte_lane got %h exp 00000F00", d); end
    bus_write(8'h00, 32'h0, 4'hF);
    repeat (2) @(negedge clk);
    total++; if (spi_cs_n !== 4'hF) begin bad++; $display("FAIL cs_manual_off got %b exp 1111", spi_cs_n); end
    bus_read(8'h02, d);
    total++; if (d !== 32'h0) begin bad++; $display("FAIL undefined_offset got %h exp 0", d); end
    bus_read(8'h04, d);
    total++; if (d !== 32'h0) begin bad++; $display("FAIL txdata_read got %h exp 0", d); end
  endtask

  task automatic test_mode0();
    int rises, cs_low, cs_err; logic [31:0] bits, d; logic to;
    loop_en = 1'b1;
    bus_write(8'h00, 32'h0700_0111, 4'hF);
    bus_write(8'h04, 32'h0000_00A5, 4'hF);
    monitor_frames(200, 4'b1101, rises, cs_low, bits, cs_err, to);
    total++; if (to) begin bad++; $display("FAIL m0_timeout got timeout exp frame end"); end
    total++; if (rises !== 8) begin bad++; $display("FAIL m0_rises got %0d exp 8", rises); end
    total++; if (cs_low !== 18) begin bad++; $display("FAIL m0_cs_low_cycles got %0d exp 18", cs_low); end
    total++; if (cs_err !== 0) begin bad++; $display("FAIL m0_cs_value got %0d wrong cycles exp 0", cs_err); end
    total++; if (bits !== 32'hA5) begin bad++; $display("FAIL m0_mosi_bits got %h exp a5", bits); end
    bus_read(8'h08, d);
    total++; if (d !== 32'h0000_00A5) begin bad++; $display("FAIL m0_rx got %h exp 000000a5", d); end
    bus_read(8'h0C, d);
    total++; if (d !== 32'h14) begin bad++; $display("FAIL m0_status got %h exp 00000014", d); end
    bus_read(8'h08, d);
    total++; if (d !== 32'h0) begin bad++; $display("FAIL rx_empty_read got %h exp 0", d); end
  endtask

  task automatic test_mode3_lsbf();
    int rises, cs_low, cs_err; logic [31:0] bits, d; logic to;
    loop_en = 1'b0; miso_val = 1'b1;
    bus_write(8'h00, 32'h0B00_001F, 4'hF);
    repeat (3) @(negedge clk);
    total++; if (spi_clk !== 1'b1) begin bad++; $display("FAIL m3_idle_clk got %b exp 1", spi_clk); end
    bus_write(8'h04, 32'h0000_00F3, 4'hF);
    monitor_frames(200, 4'b1110, rises, cs_low, bits, cs_err, to);
    total++; if (to || rises !== 12) begin bad++; $display("FAIL m3_rises got %0d (timeout=%b) exp 12", rises, to); end
    total++; if (bits[11:0] !== 12'hCF0) begin bad++; $display("FAIL m3_mosi_order got %h exp cf0", bits[11:0]); end
    total++; if (cs_low !== 26 || cs_err !== 0) begin bad++; $display("FAIL m3_cs got low=%0d err=%0d exp low=26 err=0", cs_low, cs_err); end
    total++; if (spi_clk !== 1'b1) begin bad++; $display("FAIL m3_end_clk got %b exp 1", spi_clk); end
    bus_read(8'h08, d);
    total++; if (d !== 32'h0000_0FFF) begin bad++; $display("FAIL m3_rx got %h exp 00000fff", d); end
    loop_en = 1'b1;
  endtask

  task automatic test_back_to_back();
    int rises, cs_low, cs_err; logic [31:0] bits, d;
    logic [31:0] words [3];
    logic to;
    words[0] = 32'hDEAD_BEEF; words[1] = 32'h1234_5678; words[2] = 32'h8000_0001;
    loop_en = 1'b1;
    bus_write(8'h00, 32'h1F03_0200, 4'hF);
    for (int i = 0; i < 3; i++) bus_write(8'h04, words[i], 4'hF);
    bus_write(8'h00, 32'h1F03_0201, 4'hF);
    monitor_frames(2000, 4'b1011, rises, cs_low, bits, cs_err, to);
    total++; if (to) begin bad++; $display("FAIL b2b_timeout got timeout exp frame end"); end
    total++; if (cs_low !== 792 || cs_err !== 0) begin bad++; $display("FAIL b2b_cs_window got low=%0d err=%0d exp low=792 err=0", cs_low, cs_err); end
    total++; if (rises !== 96) begin bad++; $display("FAIL b2b_rises got %0d exp 96", rises); end
    total++; if (bits !== 32'h8000_0001) begin bad++; $display("FAIL b2b_last_mosi got %h exp 80000001", bits); end
    for (int i = 0; i < 3; i++) begin
      bus_read(8'h08, d);
      total++; if (d !== words[i]) begin bad++; $display("FAIL b2b_rx%0d got %h exp %h", i, d, words[i]); end
    end
  endtask

  task automatic test_fifo_full_ovf();
    logic [31:0] d;
    bus_write(8'h00, 32'h0, 4'hF);
    for (int i = 0; i <= FIFO_DEPTH; i++) bus_write(8'h04, 32'h10 + i, 4'hF);
    bus_read(8'h0C, d);
    total++; if (d !== 32'h0000_0812) begin bad++; $display("FAIL tx_full_status got %h exp 00000812", d); end
    bus_write(8'h00, 32'h0700_0011, 4'hF);
    repeat (5) @(negedge clk);
    bus_write(8'h04, 32'h0000_0018, 4'hF);
    repeat (400) @(negedge clk);
    bus_read(8'h0C, d);
    total++; if (d !== 32'h0008_002C) begin bad++; $display("FAIL rx_ovf_status got %h exp 0008002c", d); end
    bus_write(8'h0C, 32'h0000_0020, 4'b0001);
    bus_read(8'h0C, d);
    total++; if (d !== 32'h0008_000C) begin bad++; $display("FAIL rx_ovf_clear got %h exp 0008000c", d); end
    for (int i = 0; i < FIFO_DEPTH; i++) begin
      bus_read(8'h08, d);
      total++; if (d !== 32'h10 + i) begin bad++; $display("FAIL ovf_rx%0d got %h exp %h", i, d, 32'h10 + i); end
    end
    bus_read(8'h0C, d);
    total++; if (d !== 32'h14) begin bad++; $display("FAIL ovf_drained got %h exp 00000014", d); end
  endtask

  task automatic test_reset_mid_frame();
    logic [31:0] d;
    bus_write(8'h00, 32'h1F03_0011, 4'hF);
    bus_write(8'h04, 32'h55AA_55AA, 4'hF);
    bus_write(8'h04, 32'h0F0F_0F0F, 4'hF);
    repeat (20) @(negedge clk);
    total++; if (spi_cs_n !== 4'b1110) begin bad++; $display("FAIL mid_cs_active got %b exp 1110", spi_cs_n); end
    #2 rst_n = 1'b0;
    #1;
    total++; if (spi_cs_n !== 4'hF || spi_clk !== 1'b0 || spi_mosi !== 1'b0) begin
      bad++; $display("FAIL async_reset_pins got cs=%b clk=%b mosi=%b exp 1111 0 0", spi_cs_n, spi_clk, spi_mosi); end
    @(negedge clk);
    rst_n = 1'b1;
    bus_read(8'h0C, d);
    total++; if (d !== 32'h14) begin bad++; $display("FAIL async_reset_status got %h exp 00000014", d); end
    bus_read(8'h00, d);
    total++; if (d !== 32'h0) begin bad++; $display("FAIL async_reset_ctrl got %h exp 0", d); end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog got no finish exp finish");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_ctrl_regs();
    test_mode0();
    test_mode3_lsbf();
    test_back_to_back();
    test_fifo_full_ovf();
    test_reset_mid_frame();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/spi_master_fifo.md
Name: spi_master_fifo

Overview:
- Parametrised next-generation SPI master for the sysio peripheral bus. It uses the same byte-lane write/read bus as the other sysio peripherals.
- Adds programmable frame length (1..DATA_W bits), MSB/LSB order, multiple chip selects with auto/manual control, and TX/RX FIFOs. Software can queue several frames without polling per frame.
- Sits beside the other sysio peripherals. Register offsets are decoded from waddr_i[3:0]/raddr_i[3:0].

Parameters:
- DATA_W, 32, maximum frame width in bits (8..32).
- CS_NUM, 4, number of chip-select outputs (1..16).
- FIFO_DEPTH, 8, entries per TX and RX FIFO (power of two, 2..256).

Ports:
- clk  in  1  system clock
- rst_n  in  1  asynchronous active-low reset
- waddr_i  in  8  write address
- data_i  in  32  write data
- sel_i  in  4  byte-lane write enables
- we_i  in  1  write strobe
- raddr_i  in  8  read address
- rd_i  in  1  read strobe
- data_o  out  32  registered read data
- spi_clk  out  1  serial clock
- spi_mosi  out  1  serial data out
- spi_miso  in  1  serial data in
- spi_cs_n  out  CS_NUM  active-low chip selects

Behaviour:
- Register map.
  - 0x0 CTRL, byte-lane writable.
    - [0] EN; [1] CPOL; [2] CPHA; [3] LSBF (1 = LSB first).
    - [4] CS_AUTO; [5] CS_MAN; [11:8] CS_IDX.
    - [23:16] DIV; [28:24] LEN (frame bits = LEN+1, clamped to DATA_W).
  - 0x4 TXDATA: write pushes data_i[DATA_W-1:0] when any sel_i bit is set. Reads return 0.
  - 0x8 RXDATA: read returns the FIFO head, zero-extended, and pops it. A read when empty returns 0 and does not pop.
  - 0xC STATUS.
    - [0] busy; [1] tx_full; [2] tx_empty; [3] rx_full; [4] rx_empty; [5] rx_ovf (sticky, write 1 to clear).
    - [15:8] tx_count; [23:16] rx_count.
  - Undefined offsets read 0.
- Bus timing.
  - data_o updates one cycle after rd_i and holds otherwise.
  - The RX pop takes effect in the same edge that data_o is loaded.
  - A TX push while full is dropped.
- Reset values.
  - All registers and FIFO pointers are 0; data_o = 0; spi_cs_n = all ones; spi_mosi = 0; spi_clk = CPOL (0).
- Clock.
  - Half SCLK period = DIV+1 clk cycles.
  - When idle, spi_clk = CPOL, re-evaluated every cycle.
- FSM states: IDLE, SETUP, SHIFT, HOLD.
  - IDLE -> SETUP when EN=1 and TX FIFO not empty.
    - Pop the TX word into the shift register; latch CPOL/CPHA/LSBF/LEN/CS_IDX for the frame.
    - If CPHA=0, drive the first bit on mosi.
  - SETUP: lasts one half period. Chip select CS_IDX is asserted during SETUP.
  - SHIFT: 2*(LEN+1) half-period edges.
    - CPHA=0: sample on odd edges, shift out on even edges.
    - CPHA=1: shift out on odd edges, sample on even edges.
  - SHIFT ends -> push the RX word (right-aligned, bit order per LSBF). If the RX FIFO is full, drop the word and set rx_ovf.
  - HOLD: one half period.
    - HOLD -> SETUP if EN=1, TX not empty and CS_AUTO=0 (back-to-back frames; CS stays low).
    - Otherwise HOLD -> IDLE.
- Chip select.
  - CS_AUTO=1: the selected line is low from SETUP through HOLD only, so it deasserts for at least one clk between frames.
  - CS_MAN=1: the selected line is forced low regardless of FSM.
  - CS_IDX >= CS_NUM: no line asserted, but the frame still shifts.
- busy = (state != IDLE) or (EN and TX not empty).
- CTRL writes while busy take effect at the next frame start. DIV changes apply immediately.
- Clearing EN mid-frame finishes the current frame, then goes to IDLE.
- Asynchronous reset mid-frame returns immediately to reset values.

Optional Feature:
- Macro SPI_MASTER_IRQ_EN.
- When defined, adds output irq_o (1 bit, reset 0) and CTRL[31:29] enable bits:
  - [29] rx_not_empty
  - [30] tx_empty
  - [31] rx_ovf
- irq_o is the registered OR of the enabled conditions (level, 1-cycle latency).
- When undefined: no irq_o port; CTRL[31:29] read 0.

Test Plan:
- CTRL = EN, mode 0, DIV=0, LEN=7, CS_AUTO, CS_IDX=1; push 0xA5 with miso looped to mosi -> 8 SCLK periods of 2 clk each; spi_cs_n = 4'b1101 during the frame; RXDATA reads 0x000000A5; afterwards STATUS busy=0, rx_empty=1.
- Mode 3 (CPOL=1, CPHA=1), LSBF=1, LEN=11; push 0x0F3 with miso tied 1 -> mosi shows bit order 1,1,0,0,1,1,1,1,0,0,0,0; idle spi_clk=1; RX = 0x00000FFF.
- CS_AUTO=0, push 3 words, LEN=31, DIV=3 -> CS stays low across all 3 frames; each frame spans 64 half periods; 3 RX entries returned in order.
- Push FIFO_DEPTH+1 words with EN=0 -> tx_full=1; tx_count=FIFO_DEPTH; extra word is dropped.
- With EN=1, run FIFO_DEPTH+1 frames without reading -> rx_ovf=1 and rx_count=FIFO_DEPTH; write 1 to STATUS[5] -> rx_ovf=0.
- Deassert rst_n mid-SHIFT -> spi_cs_n all ones, FIFOs empty and STATUS = 0x00000014 on the next read (tx_empty and rx_empty set, all counts 0).
